// File: rtl/virtual_ram_pipe.sv
// virtual_ram_pipe: simulation memory model with fixed-latency, in-order,
// backpressured request/response interface.
//
// Requests are accepted when req_valid & req_ready. The access is performed
// at the accept edge, 64 bits per lane. Its result then travels down a
// LATENCY-deep pipeline into a DEPTH-entry response FIFO. A credit counter
// (outstanding) caps in-flight requests at DEPTH, so the FIFO can never
// overflow and the pipeline never stalls.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_addr                   byte address, bus-aligned internally
//   req_wen, req_wdata, req_wmask, req_id   request payload
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_id, resp_wen, resp_err response payload (0 when idle)
//
// Optional build macro VIRTUAL_RAM_PIPE_TRACE_EN: prints one line per accept
// and per response fire, stamped with a cycle counter.
//
// Backing store: sparse 64-bit word store. It is reached only through
// ram_read_helper(en, addr) and ram_write_helper(addr, wdata, wmask64, en).
module virtual_ram_pipe #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH      = 4,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter logic [63:0] SIZE       = 64'h0800_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_addr,
  input  logic                    req_wen,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  input  logic [ID_WIDTH-1:0]     req_id,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [ID_WIDTH-1:0]     resp_id,
  output logic                    resp_wen,
  output logic                    resp_err
);

  localparam int unsigned NumLanes = DATA_WIDTH / 64;
  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;

  // Sparse word store, keyed by byte address / 8.
  logic [63:0] mem [logic [60:0]];

  function automatic logic [63:0] ram_read_helper(input logic en, input logic [63:0] addr);
    logic [63:0] rd;
    rd = '0;
    if (en && mem.exists(addr[63:3])) rd = mem[addr[63:3]];
    return rd;
  endfunction

  function automatic void ram_write_helper(input logic [63:0] addr, input logic [63:0] wdata,
                                           input logic [63:0] wmask64, input logic en);
    logic [63:0] old;
    if (en) begin
      old = mem.exists(addr[63:3]) ? mem[addr[63:3]] : 64'h0;
      mem[addr[63:3]] = (old & ~wmask64) | (wdata & wmask64);
    end
  endfunction

  logic accept, fire;
  logic [63:0] aligned;
  logic [64:0] end_ext, limit_ext;
  logic req_err;
  logic do_rd, do_wr;
  logic [63:0] lane_mask [NumLanes];

  logic [CntW-1:0] outstanding_q, outstanding_d;

  logic [LATENCY-1:0]  pipe_valid_q, pipe_wen_q, pipe_err_q;
  logic [ID_WIDTH-1:0]   pipe_id_q    [LATENCY];
  logic [DATA_WIDTH-1:0] pipe_rdata_q [LATENCY];

  logic [DEPTH-1:0]      fifo_wen_q, fifo_err_q;
  logic [ID_WIDTH-1:0]   fifo_id_q    [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_rdata_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push;

  // Address decode and range check; 65-bit sums make a wrap past 2^64 an error.
  always_comb begin
    aligned   = req_addr & ~(64'(NumBytes) - 64'd1);
    end_ext   = {1'b0, aligned} + 65'(NumBytes);
    limit_ext = {1'b0, BASE_ADDR} + {1'b0, SIZE};
    req_err   = !((aligned >= BASE_ADDR) && (end_ext <= limit_ext));
  end

  always_comb begin
    for (int k = 0; k < NumLanes; k++) begin
      lane_mask[k] = '0;
      for (int b = 0; b < 8; b++) begin
        lane_mask[k][8*b +: 8] = {8{req_wmask[8*k+b]}};
      end
    end
  end

  assign req_ready  = !reset && (outstanding_q < CntW'(DEPTH));
  assign accept     = req_valid && req_ready;
  assign do_rd      = accept && !req_err && !req_wen;
  assign do_wr      = accept && !req_err && req_wen;
  assign resp_valid = (count_q != '0);
  assign fire       = resp_valid && resp_ready;
  assign push       = pipe_valid_q[LATENCY-1];

  // Outputs read as zero whenever the FIFO is empty (including in reset).
  always_comb begin
    resp_rdata = '0;
    resp_id    = '0;
    resp_wen   = 1'b0;
    resp_err   = 1'b0;
    if (resp_valid) begin
      resp_rdata = fifo_rdata_q[rd_ptr_q];
      resp_id    = fifo_id_q[rd_ptr_q];
      resp_wen   = fifo_wen_q[rd_ptr_q];
      resp_err   = fifo_err_q[rd_ptr_q];
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({accept, fire})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    count_d = count_q;
    unique case ({push, fire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Memory access at the accept edge plus the latency shift pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid_q <= '0;
      pipe_wen_q   <= '0;
      pipe_err_q   <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        pipe_id_q[s]    <= '0;
        pipe_rdata_q[s] <= '0;
      end
    end else begin
      pipe_valid_q[0] <= accept;
      pipe_wen_q[0]   <= req_wen;
      pipe_err_q[0]   <= req_err;
      pipe_id_q[0]    <= req_id;
      for (int k = 0; k < NumLanes; k++) begin
        // Zero-mask lanes still call the helper; the mask leaves the word intact.
        if (do_wr) begin
          ram_write_helper(aligned + 64'(8*k), req_wdata[64*k +: 64], lane_mask[k], 1'b1);
        end
        pipe_rdata_q[0][64*k +: 64] <= ram_read_helper(do_rd, aligned + 64'(8*k));
      end
      for (int s = 1; s < LATENCY; s++) begin
        pipe_valid_q[s] <= pipe_valid_q[s-1];
        pipe_wen_q[s]   <= pipe_wen_q[s-1];
        pipe_err_q[s]   <= pipe_err_q[s-1];
        pipe_id_q[s]    <= pipe_id_q[s-1];
        pipe_rdata_q[s] <= pipe_rdata_q[s-1];
      end
    end
  end

  // Response FIFO and credit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
    end else begin
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      if (push) begin
        fifo_wen_q[wr_ptr_q]   <= pipe_wen_q[LATENCY-1];
        fifo_err_q[wr_ptr_q]   <= pipe_err_q[LATENCY-1];
        fifo_id_q[wr_ptr_q]    <= pipe_id_q[LATENCY-1];
        fifo_rdata_q[wr_ptr_q] <= pipe_rdata_q[LATENCY-1];
        wr_ptr_q               <= wr_ptr_q + PtrW'(1);
      end
      if (fire) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

`ifdef VIRTUAL_RAM_PIPE_TRACE_EN
  logic [63:0] cycle_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (accept) begin
        if (req_wen) begin
          $display("[vram %0d] W addr=%h id=%0h err=%0b wdata=%h wmask=%h", cycle_q, aligned,
                   req_id, req_err, req_wdata, req_wmask);
        end else begin
          $display("[vram %0d] R addr=%h id=%0h err=%0b", cycle_q, aligned, req_id, req_err);
        end
      end
      if (fire) $display("[vram %0d] resp id=%0h rdata=%h", cycle_q, resp_id, resp_rdata);
    end
  end
`endif

endmodule

// File: tb/tb_virtual_ram_pipe.sv
module tb_virtual_ram_pipe;

  localparam logic [63:0] Base = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic [3:0]  req_id;
  logic        resp_valid, resp_ready, resp_wen, resp_err;
  logic [63:0] resp_rdata;
  logic [3:0]  resp_id;

  // 128-bit bus instance.
  logic         w_req_valid, w_req_ready, w_req_wen;
  logic [63:0]  w_req_addr;
  logic [127:0] w_req_wdata, w_resp_rdata;
  logic [15:0]  w_req_wmask;
  logic [3:0]   w_req_id, w_resp_id;
  logic         w_resp_valid, w_resp_ready, w_resp_wen, w_resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  virtual_ram_pipe #(.DATA_WIDTH(64), .ID_WIDTH(4), .LATENCY(2), .DEPTH(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wen    (req_wen),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .req_id     (req_id),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_id    (resp_id),
    .resp_wen   (resp_wen),
    .resp_err   (resp_err)
  );

  virtual_ram_pipe #(.DATA_WIDTH(128), .ID_WIDTH(4), .LATENCY(2), .DEPTH(4)) u_dut_wide (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (w_req_valid),
    .req_ready  (w_req_ready),
    .req_addr   (w_req_addr),
    .req_wen    (w_req_wen),
    .req_wdata  (w_req_wdata),
    .req_wmask  (w_req_wmask),
    .req_id     (w_req_id),
    .resp_valid (w_resp_valid),
    .resp_ready (w_resp_ready),
    .resp_rdata (w_resp_rdata),
    .resp_id    (w_resp_id),
    .resp_wen   (w_resp_wen),
    .resp_err   (w_resp_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request and hold it until accepted (bounded wait).
  task automatic issue(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                       input logic [7:0] wmask, input logic [3:0] id);
    int n = 0;
    req_valid = 1'b1; req_addr = addr; req_wen = wen;
    req_wdata = wdata; req_wmask = wmask; req_id = id;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) check("issue_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Wait for the head response, check it, and consume it.
  task automatic get_resp(input string tag, input logic [3:0] id, input logic [63:0] rdata,
                          input logic err, input logic wen);
    int n = 0;
    resp_ready = 1'b1;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!resp_valid) begin
      check({tag, "_timeout"}, 1'b0, 1'b1);
    end else begin
      check({tag, "_id"}, resp_id, id);
      check({tag, "_rdata"}, resp_rdata, rdata);
      check({tag, "_err"}, resp_err, err);
      check({tag, "_wen"}, resp_wen, wen);
      @(posedge clk); #1;
    end
  endtask

  task automatic wide_xfer(input string tag, input logic [63:0] addr, input logic wen,
                           input logic [127:0] wdata, input logic [15:0] wmask,
                           input logic [127:0] exp_rdata);
    int n = 0;
    w_req_valid = 1'b1; w_req_addr = addr; w_req_wen = wen;
    w_req_wdata = wdata; w_req_wmask = wmask; w_req_id = 4'h9;
    while (!w_req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    w_req_valid = 1'b0;
    n = 0;
    while (!w_resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!w_resp_valid) begin
      check({tag, "_timeout"}, 1'b0, 1'b1);
    end else begin
      check({tag, "_rdata"}, w_resp_rdata, exp_rdata);
      check({tag, "_err"}, w_resp_err, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_wdata = '0; req_wmask = '0;
    req_id = '0; resp_ready = 1'b1;
    w_req_valid = 1'b0; w_req_addr = '0; w_req_wen = 1'b0; w_req_wdata = '0;
    w_req_wmask = '0; w_req_id = '0; w_resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rdata", resp_rdata, 64'h0);
    check("rst_id", resp_id, 4'h0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1'b1);

    // Write then back-to-back read of the same word; write accepted at edge t.
    issue(Base, 1'b1, 64'hDEAD_BEEF_0123_4567, 8'hFF, 4'h1);
    issue(Base, 1'b0, 64'h0, 8'h00, 4'h2);
    check("lat_early", resp_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_at_t2", resp_valid, 1'b1);
    get_resp("wr1", 4'h1, 64'h0, 1'b0, 1'b1);
    get_resp("rd1", 4'h2, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);

    // Partial byte mask over an all-ones word.
    issue(Base + 64'h8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'h3);
    issue(Base + 64'h8, 1'b1, 64'h0, 8'h0F, 4'h4);
    issue(Base + 64'hC, 1'b0, 64'h0, 8'h00, 4'h5);
    get_resp("pm_w0", 4'h3, 64'h0, 1'b0, 1'b1);
    get_resp("pm_w1", 4'h4, 64'h0, 1'b0, 1'b1);
    get_resp("pm_rd", 4'h5, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0);

    // Backpressure: seed six words, then hold resp_ready low.
    for (int i = 0; i < 6; i++) begin
      issue(Base + 64'h100 + 64'(8*i), 1'b1, 64'h0101_0101_0101_0101 * 64'(i+1), 8'hFF, 4'(i));
      get_resp("bp_seed", 4'(i), 64'h0, 1'b0, 1'b1);
    end
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(Base + 64'h100 + 64'(8*i), 1'b0, 64'h0, 8'h00, 4'(i));
    check("bp_ready_low", req_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_ready_still_low", req_ready, 1'b0);
    check("bp_head_valid", resp_valid, 1'b1);
    check("bp_head_id", resp_id, 4'h0);
    fork
      begin
        issue(Base + 64'h120, 1'b0, 64'h0, 8'h00, 4'h4);
        issue(Base + 64'h128, 1'b0, 64'h0, 8'h00, 4'h5);
      end
      begin
        for (int j = 0; j < 6; j++) begin
          get_resp("bp_order", 4'(j), 64'h0101_0101_0101_0101 * 64'(j+1), 1'b0, 1'b0);
        end
      end
    join
    check("bp_drained_valid", resp_valid, 1'b0);
    check("bp_drained_ready", req_ready, 1'b1);

    // Range checks: below base, at end of window, last valid word, 64-bit wrap.
    issue(64'h7FFF_FFF8, 1'b0, 64'h0, 8'h00, 4'h6);
    get_resp("oor_rd", 4'h6, 64'h0, 1'b1, 1'b0);
    issue(64'h8800_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'h7);
    get_resp("oor_wr", 4'h7, 64'h0, 1'b1, 1'b1);
    issue(64'h87FF_FFF8, 1'b0, 64'h0, 8'h00, 4'h8);
    get_resp("last_word", 4'h8, 64'h0, 1'b0, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0, 8'h00, 4'hA);
    get_resp("wrap", 4'hA, 64'h0, 1'b1, 1'b0);
    issue(Base, 1'b0, 64'h0, 8'h00, 4'hB);
    get_resp("oor_mem_intact", 4'hB, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);

    // Reset with three reads in flight.
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(Base, 1'b0, 64'h0, 8'h00, 4'(12+i));
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", resp_valid, 1'b0);
    check("mid_rst_ready", req_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("after_rst_ready", req_ready, 1'b1);
    resp_ready = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        if (resp_valid) seen = 1'b1;
      end
      check("no_stale_resp", seen, 1'b0);
    end
    issue(Base, 1'b0, 64'h0, 8'h00, 4'hF);
    get_resp("after_rst_rd", 4'hF, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);

    // 128-bit bus: unaligned address selects the 0x10 beat; check both lanes.
    wide_xfer("wide_wr", 64'h8000_0018, 1'b1, 128'h1111_1111_1111_1111_2222_2222_2222_2222,
              16'hFFFF, 128'h0);
    wide_xfer("wide_rd", 64'h8000_0010, 1'b0, 128'h0, 16'h0000,
              128'h1111_1111_1111_1111_2222_2222_2222_2222);
    wide_xfer("wide_pwr", 64'h8000_0010, 1'b1, 128'h0, 16'h00F0, 128'h0);
    wide_xfer("wide_prd", 64'h8000_001F, 1'b0, 128'h0, 16'h0000,
              128'h1111_1111_1111_1111_0000_0000_2222_2222);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
